// File: rtl/dmem_if.sv
// Request/response bundle between the CPU data port and dmem_access_unit.
// Master drives requests and observes the single-cycle response pulse.
interface dmem_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic        req_sign;
    logic [2:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;

    modport master (
        output req_valid, req_we, req_sign, req_size, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_fault
    );

    modport slave (
        input  req_valid, req_we, req_sign, req_size, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_fault
    );
endinterface

// File: rtl/dmem_access_unit.sv
// Multi-cycle data-memory access unit: wait-state latency, base relocation,
// byte/half/word lanes with sign extension, and fault reporting.
module dmem_access_unit #(
    parameter int          DEPTH       = 2048,
    parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
    parameter int          WAIT_STATES = 1
) (
    input  logic   clk,
    input  logic   rst_n,
    dmem_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    typedef struct packed {
        logic        we;
        logic        sign;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt;
    req_t        req_in, lat, acc;
    logic        accept, access;
    logic [31:0] rdata_q;
    logic        fault_q;

    logic [31:0] mem [DEPTH];

    logic [31:0] off;
    logic [AW-1:0] idx;
    logic        legal, fault;
    logic [31:0] word, sh_b, sh_h, rd_val, wrep;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [3:0]  be;

    assign req_in = '{we: bus.req_we, sign: bus.req_sign, size: bus.req_size,
                      addr: bus.req_addr, wdata: bus.req_wdata};
    assign accept = bus.req_valid && (state == S_IDLE);
    assign access = (state == S_IDLE && accept && WAIT_STATES == 0) ||
                    (state == S_WAIT && cnt == 4'd0);
    // With zero wait states the access happens on the acceptance edge itself,
    // so the live request fields feed the datapath while idle.
    assign acc = (state == S_IDLE) ? req_in : lat;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
            S_WAIT:  if (cnt == 4'd0) state_nxt = S_RESP;
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        bus.req_ready = (state == S_IDLE);
        bus.rsp_valid = (state == S_RESP);
        bus.rsp_rdata = rdata_q;
        bus.rsp_fault = fault_q;
    end

    // Address decode and fault evaluation
    always_comb begin
        off   = acc.addr - BASE_ADDR;
        idx   = off[AW+1:2];
        legal = (acc.size == 3'b001) || (acc.size == 3'b010) || (acc.size == 3'b100);
        fault = ((off >> (AW + 2)) != 32'd0) || !legal ||
                (acc.size == 3'b010 && off[0]) ||
                (acc.size == 3'b100 && off[1:0] != 2'b00);
    end

    // Lane select / extension on reads, lane enables and replication on writes
    always_comb begin
        word   = mem[idx];
        sh_b   = word >> {off[1:0], 3'b000};
        sh_h   = word >> {off[1], 4'b0000};
        lane_b = sh_b[7:0];
        lane_h = sh_h[15:0];
        case (acc.size)
            3'b001: begin
                rd_val = {{24{acc.sign & lane_b[7]}}, lane_b};
                be     = 4'b0001 << off[1:0];
                wrep   = {4{acc.wdata[7:0]}};
            end
            3'b010: begin
                rd_val = {{16{acc.sign & lane_h[15]}}, lane_h};
                be     = off[1] ? 4'b1100 : 4'b0011;
                wrep   = {2{acc.wdata[15:0]}};
            end
            default: begin
                rd_val = word;
                be     = 4'b1111;
                wrep   = acc.wdata;
            end
        endcase
    end

    // Storage is deliberately not reset; a write abandoned by reset never lands.
    always_ff @(posedge clk) begin
        if (rst_n && access && acc.we && !fault) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) mem[idx][8*b +: 8] <= wrep[8*b +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= 4'd0;
            lat     <= '0;
            rdata_q <= 32'd0;
            fault_q <= 1'b0;
        end else begin
            if (accept) begin
                lat <= req_in;
                cnt <= (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
            end else if (state == S_WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (access) begin
                fault_q <= fault;
                rdata_q <= (fault || acc.we) ? 32'd0 : rd_val;
            end
        end
    end
endmodule

// File: tb/tb_dmem_access_unit.sv
// Bench for dmem_access_unit: two instances (1 and 3 wait states) checked every
// cycle against a byte-addressed transaction model, plus directed literal cases.
module tb_dmem_access_unit;
    localparam logic [31:0] BASE  = 32'h1001_0000;
    localparam int          DEPTH = 2048;
    localparam logic [31:0] TOP   = BASE + 32'(DEPTH * 4) - 32'd4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    dmem_if if0 ();
    dmem_if if1 ();

    dmem_access_unit #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .bus(if0));
    dmem_access_unit #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(3)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .bus(if1));

    logic        rv [2];
    logic        we [2];
    logic        sg [2];
    logic [2:0]  sz [2];
    logic [31:0] ad [2];
    logic [31:0] wd [2];
    logic        rdy [2];
    logic        rvo [2];
    logic [31:0] rdt [2];
    logic        flt [2];

    assign if0.req_valid = rv[0]; assign if1.req_valid = rv[1];
    assign if0.req_we    = we[0]; assign if1.req_we    = we[1];
    assign if0.req_sign  = sg[0]; assign if1.req_sign  = sg[1];
    assign if0.req_size  = sz[0]; assign if1.req_size  = sz[1];
    assign if0.req_addr  = ad[0]; assign if1.req_addr  = ad[1];
    assign if0.req_wdata = wd[0]; assign if1.req_wdata = wd[1];
    assign rdy[0] = if0.req_ready; assign rdy[1] = if1.req_ready;
    assign rvo[0] = if0.rsp_valid; assign rvo[1] = if1.rsp_valid;
    assign rdt[0] = if0.rsp_rdata; assign rdt[1] = if1.rsp_rdata;
    assign flt[0] = if0.rsp_fault; assign flt[1] = if1.rsp_fault;

    function automatic int ws(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit [7:0]    mm [int unsigned];      // key = dut*65536 + byte offset
    int          cl [2];                 // non-idle cycles remaining
    logic [31:0] lr [2];
    logic        lf [2];
    logic        lk [2];                 // expected rdata is known
    logic        p_we [2], p_sg [2];
    logic [2:0]  p_sz [2];
    logic [31:0] p_ad [2], p_wd [2];

    task automatic model_access(input int i);
        logic [31:0] off, v;
        int n;
        bit known;
        off = p_ad[i] - BASE;
        n = (p_sz[i] == 3'd1) ? 1 : (p_sz[i] == 3'd2) ? 2 : (p_sz[i] == 3'd4) ? 4 : 0;
        if (off >= 32'(DEPTH * 4) || n == 0 || (off % n) != 0) begin
            lr[i] = 32'd0; lf[i] = 1'b1; lk[i] = 1'b1;
        end else if (p_we[i]) begin
            for (int b = 0; b < n; b++)
                mm[i * 65536 + int'(off) + b] = p_wd[i][8*b +: 8];
            lr[i] = 32'd0; lf[i] = 1'b0; lk[i] = 1'b1;
        end else begin
            v = 32'd0; known = 1'b1;
            for (int b = 0; b < n; b++) begin
                if (mm.exists(i * 65536 + int'(off) + b))
                    v = v | (32'(mm[i * 65536 + int'(off) + b]) << (8 * b));
                else known = 1'b0;
            end
            if (p_sg[i] && n < 4 && v[8*n-1]) v = v | (~32'd0 << (8 * n));
            lr[i] = v; lf[i] = 1'b0; lk[i] = known;
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                cl[i] = 0; lr[i] = 32'd0; lf[i] = 1'b0; lk[i] = 1'b1;
                chk("rst_ready", 32'(rdy[i]), 32'd1);
                chk("rst_rsp_valid", 32'(rvo[i]), 32'd0);
                chk("rst_rdata", rdt[i], 32'd0);
                chk("rst_fault", 32'(flt[i]), 32'd0);
            end else begin
                int old;
                chk("ready", 32'(rdy[i]), 32'(cl[i] == 0));
                chk("rsp_valid", 32'(rvo[i]), 32'(cl[i] == 1));
                chk("fault", 32'(flt[i]), 32'(lf[i]));
                if (lk[i]) chk("rdata", rdt[i], lr[i]);
                old = cl[i];
                if (cl[i] > 0) cl[i]--;
                else if (rv[i]) begin
                    cl[i] = ws(i) + 1;
                    p_we[i] = we[i]; p_sg[i] = sg[i]; p_sz[i] = sz[i];
                    p_ad[i] = ad[i]; p_wd[i] = wd[i];
                end
                if (cl[i] == 1 && old != 1) model_access(i);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_req(input int i, input logic w, input logic s, input logic [2:0] z,
                          input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output logic f);
        int n;
        rd = 32'd0; f = 1'b0;
        @(posedge clk); #1;
        rv[i] = 1'b1; we[i] = w; sg[i] = s; sz[i] = z; ad[i] = a; wd[i] = d;
        n = 0;
        @(negedge clk);
        while (!rdy[i] && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) begin
            chk("accept_timeout", 32'd0, 32'd1);
            rv[i] = 1'b0;
            return;
        end
        @(posedge clk); #1;
        rv[i] = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!rvo[i] && n < 40);
        chk("latency", 32'(n), 32'(ws(i) + 1));
        rd = rdt[i]; f = flt[i];
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic f;
        int acc_t [3];
        int na, np, t;

        for (int i = 0; i < 2; i++) begin
            rv[i] = 1'b0; we[i] = 1'b0; sg[i] = 1'b0; sz[i] = 3'd4;
            ad[i] = BASE; wd[i] = 32'd0;
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Seed the address window used by the random phase.
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 8; k++)
                do_req(i, 1'b1, 1'b0, 3'd4, BASE + 32'(4 * k), $urandom, rd, f);
            do_req(i, 1'b1, 1'b0, 3'd4, TOP, 32'hA5A5_0001, rd, f);
        end

        // Word round trip
        do_req(0, 1'b1, 1'b0, 3'd4, 32'h1001_0004, 32'hDEAD_BEEF, rd, f);
        chk("rt_write_fault", 32'(f), 32'd0);
        do_req(0, 1'b0, 1'b0, 3'd4, 32'h1001_0004, 32'd0, rd, f);
        chk("rt_read_data", rd, 32'hDEAD_BEEF);
        chk("rt_read_fault", 32'(f), 32'd0);

        // Lane merge and extension
        do_req(0, 1'b1, 1'b0, 3'd4, 32'h1001_0008, 32'h1122_3344, rd, f);
        do_req(0, 1'b1, 1'b0, 3'd1, 32'h1001_000A, 32'h0000_00F0, rd, f);
        do_req(0, 1'b0, 1'b0, 3'd4, 32'h1001_0008, 32'd0, rd, f);
        chk("merge_word", rd, 32'h11F0_3344);
        do_req(0, 1'b0, 1'b1, 3'd1, 32'h1001_000A, 32'd0, rd, f);
        chk("byte_signed", rd, 32'hFFFF_FFF0);
        do_req(0, 1'b0, 1'b0, 3'd1, 32'h1001_000A, 32'd0, rd, f);
        chk("byte_unsigned", rd, 32'h0000_00F0);
        do_req(0, 1'b0, 1'b1, 3'd2, 32'h1001_000A, 32'd0, rd, f);
        chk("half_signed", rd, 32'h0000_11F0);

        // Faults
        do_req(0, 1'b0, 1'b0, 3'd2, 32'h1001_0001, 32'd0, rd, f);
        chk("misaligned_half_fault", 32'(f), 32'd1);
        chk("misaligned_half_rdata", rd, 32'd0);
        do_req(0, 1'b1, 1'b0, 3'd4, 32'h1000_FFFC, 32'h0BAD_0BAD, rd, f);
        chk("below_base_fault", 32'(f), 32'd1);
        do_req(0, 1'b0, 1'b0, 3'd4, TOP, 32'd0, rd, f);
        chk("top_unchanged", rd, 32'hA5A5_0001);
        chk("top_fault", 32'(f), 32'd0);
        do_req(0, 1'b0, 1'b0, 3'b011, 32'h1001_0004, 32'd0, rd, f);
        chk("illegal_size_fault", 32'(f), 32'd1);

        // Handshake: continuous req_valid on the 3-wait-state instance
        @(posedge clk); #1;
        rv[1] = 1'b1; we[1] = 1'b0; sg[1] = 1'b0; sz[1] = 3'd4; ad[1] = BASE;
        na = 0; np = 0; t = 0;
        while (na < 3 && t < 40) begin
            @(negedge clk); t++;
            if (rvo[1]) np++;
            if (rdy[1]) begin acc_t[na] = t; na++; end
        end
        @(posedge clk); #1 rv[1] = 1'b0;
        repeat (6) begin @(negedge clk); if (rvo[1]) np++; end
        chk("hs_accepts", 32'(na), 32'd3);
        chk("hs_spacing_1", 32'(acc_t[1] - acc_t[0]), 32'd5);
        chk("hs_spacing_2", 32'(acc_t[2] - acc_t[1]), 32'd5);
        chk("hs_responses", 32'(np), 32'd3);

        // Reset in the middle of a write's wait period
        do_req(1, 1'b1, 1'b0, 3'd4, 32'h1001_0010, 32'h1234_5678, rd, f);
        do_req(1, 1'b0, 1'b0, 3'd4, 32'h1001_0010, 32'd0, rd, f);
        chk("pre_reset_read", rd, 32'h1234_5678);
        @(posedge clk); #1;
        rv[1] = 1'b1; we[1] = 1'b1; sz[1] = 3'd4; ad[1] = 32'h1001_0010; wd[1] = 32'hCAFE_0000;
        @(negedge clk);
        @(posedge clk); #1 rv[1] = 1'b0;
        @(posedge clk); #2 rst_n = 1'b0;
        #1;
        chk("async_rst_ready", 32'(rdy[1]), 32'd1);
        chk("async_rst_valid", 32'(rvo[1]), 32'd0);
        chk("async_rst_rdata", rdt[1], 32'd0);
        chk("async_rst_fault", 32'(flt[1]), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        do_req(1, 1'b0, 1'b0, 3'd4, 32'h1001_0010, 32'd0, rd, f);
        chk("post_reset_read", rd, 32'h1234_5678);

        // Randomised traffic on both instances, including ignored field changes
        repeat (2000) begin
            @(posedge clk); #1;
            for (int i = 0; i < 2; i++) begin
                rv[i] = ($urandom_range(0, 2) != 0);
                we[i] = $urandom_range(0, 1) == 1;
                sg[i] = $urandom_range(0, 1) == 1;
                case ($urandom_range(0, 7))
                    0, 1:    sz[i] = 3'b001;
                    2, 3:    sz[i] = 3'b010;
                    4, 5:    sz[i] = 3'b100;
                    6:       sz[i] = 3'b011;
                    default: sz[i] = 3'(($urandom_range(0, 1) == 1) ? 7 : 0);
                endcase
                case ($urandom_range(0, 9))
                    0:       ad[i] = BASE - 32'd4;
                    1:       ad[i] = TOP + 32'($urandom_range(0, 3));
                    2:       ad[i] = BASE + 32'(DEPTH * 4);
                    default: ad[i] = BASE + 32'($urandom_range(0, 31));
                endcase
                wd[i] = $urandom;
            end
        end
        @(posedge clk); #1 rv[0] = 1'b0; rv[1] = 1'b0;
        repeat (8) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
